// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: per-stage stall/flush,
// PC redirect, and the interrupt entry/exit state machine with its IACK_n handshake.
module pipeline_ctrl #(
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ACKI_n,
  input  logic        ACKD_n,
  input  logic        mreq,
  input  logic        load_use,
  input  logic        jump_ex,
  input  logic        jump_mem,
  input  logic        jump_wb,
  input  logic        mret_ex,
  input  logic [31:0] pc_id,
  input  logic [2:0]  OINT_n,
  output logic        IACK_n,
  output logic        stall_pc,
  output logic        stall_if_id,
  output logic        stall_id_ex,
  output logic        stall_ex_mem,
  output logic        stall_mem_wb,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        flush_ex_mem,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] epc,
  output logic [1:0]  cause,
  output logic        mie
);

  typedef enum logic [1:0] {RUN, ACK, REDIRECT} state_t;

  state_t      state, state_next;
  logic [2:0]  irq_meta, irq;
  logic [1:0]  lvl;
  logic        pending, irq_cause, dmem_wait, take_ok;
  logic        valid_id, set_mie, clr_mie, load_irq;
  logic [31:0] vec_pc;

  // Flops hold the inverted (active-high) request so reset means "nothing pending".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_meta <= 3'b000;
      irq      <= 3'b000;
    end else begin
      irq_meta <= ~OINT_n;
      irq      <= irq_meta;
    end
  end

  always_comb begin
    if (irq[2])      lvl = 2'd2;
    else if (irq[1]) lvl = 2'd1;
    else             lvl = 2'd0;
  end

  always_comb begin
    case (cause)
      2'd2:    irq_cause = irq[2];
      2'd1:    irq_cause = irq[1];
      default: irq_cause = irq[0];
    endcase
  end

  assign pending   = |irq;
  assign dmem_wait = mreq & ACKD_n;
  assign take_ok   = pending & mie & valid_id & ~jump_ex & ~jump_mem & ~ACKI_n;
  assign vec_pc    = VEC_BASE + VEC_STRIDE * {30'd0, cause};

  always_comb begin
    state_next   = state;
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    stall_mem_wb = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = 32'd0;
    set_mie      = 1'b0;
    clr_mie      = 1'b0;
    load_irq     = 1'b0;
    case (state)
      RUN: begin
        if (dmem_wait) begin
          {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb} = 5'b11111;
        end else if (jump_wb) begin
          {flush_if_id, flush_id_ex, flush_ex_mem} = 3'b111;
        end else if (mret_ex) begin
          redirect    = 1'b1;
          redirect_pc = epc;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          set_mie     = 1'b1;
        end else if (load_use) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (take_ok) begin
          stall_pc    = 1'b1;
          flush_if_id = 1'b1;
          load_irq    = 1'b1;
          state_next  = ACK;
        end else if (ACKI_n) begin
          stall_pc    = 1'b1;
          flush_if_id = 1'b1;
        end
      end
      ACK: begin
        // Fetch is frozen and bubbles fed in so older instructions drain while acknowledged.
        if (dmem_wait) begin
          {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb} = 5'b11111;
        end else begin
          stall_pc    = 1'b1;
          flush_if_id = 1'b1;
        end
        if (!irq_cause) state_next = REDIRECT;
      end
      REDIRECT: begin
        redirect    = 1'b1;
        redirect_pc = vec_pc;
        if (dmem_wait) begin
          {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb} = 5'b11111;
        end else begin
          flush_if_id = 1'b1;
          clr_mie     = 1'b1;
          state_next  = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      IACK_n   <= 1'b1;
      mie      <= 1'b1;
      epc      <= 32'd0;
      cause    <= 2'd0;
      valid_id <= 1'b0;
    end else begin
      state  <= state_next;
      IACK_n <= (state_next != ACK);
      if (set_mie)      mie <= 1'b1;
      else if (clr_mie) mie <= 1'b0;
      if (load_irq) begin
        epc   <= pc_id;
        cause <= lvl;
      end
      if (flush_if_id)       valid_id <= 1'b0;
      else if (!stall_if_id) valid_id <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed per-cycle vectors push expected outputs,
// a negedge monitor pops and compares them.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ACKI_n, ACKD_n, mreq, load_use, jump_ex, jump_mem, jump_wb, mret_ex;
  logic [31:0] pc_id;
  logic [2:0]  OINT_n;
  logic        IACK_n, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
  logic        flush_if_id, flush_id_ex, flush_ex_mem, redirect, mie;
  logic [31:0] redirect_pc, epc;
  logic [1:0]  cause;

  // Input flag bits: {mreq, ACKD_n, ACKI_n, load_use, jump_ex, jump_mem, jump_wb, mret_ex}
  localparam logic [7:0] F_IDLE = 8'h00, F_DMEM = 8'hC0, F_ACKI = 8'h20, F_LU = 8'h10;
  localparam logic [7:0] F_JEX = 8'h08, F_JMEM = 8'h04, F_JWB = 8'h02, F_MRET = 8'h01;
  // Control bits: {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb, flush_if_id, flush_id_ex, flush_ex_mem}
  localparam logic [7:0] C_NONE = 8'b00000_000, C_STALL = 8'b11111_000, C_FL3 = 8'b00000_111;
  localparam logic [7:0] C_LU = 8'b11000_010, C_SPF = 8'b10000_100, C_MRET = 8'b00000_110;
  localparam logic [7:0] C_FIF = 8'b00000_100;

  typedef struct {
    string       name;
    logic [7:0]  ctrl;
    logic        redir;
    logic [31:0] rpc;
    logic        iack;
    logic        mie;
    logic [1:0]  cause;
    logic [31:0] epc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  pipeline_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ACKI_n(ACKI_n), .ACKD_n(ACKD_n), .mreq(mreq),
    .load_use(load_use), .jump_ex(jump_ex), .jump_mem(jump_mem), .jump_wb(jump_wb),
    .mret_ex(mret_ex), .pc_id(pc_id), .OINT_n(OINT_n), .IACK_n(IACK_n),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
    .stall_ex_mem(stall_ex_mem), .stall_mem_wb(stall_mem_wb), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem), .redirect(redirect),
    .redirect_pc(redirect_pc), .epc(epc), .cause(cause), .mie(mie)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [7:0] flags, input logic [2:0] oint, input logic [31:0] pc);
    @(posedge clk);
    #1;
    {mreq, ACKD_n, ACKI_n, load_use, jump_ex, jump_mem, jump_wb, mret_ex} = flags;
    OINT_n = oint;
    pc_id  = pc;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] ctrl, input logic redir,
                             input logic [31:0] rpc, input logic iack, input logic m,
                             input logic [1:0] c, input logic [31:0] e);
    exp_t x;
    x.name = name; x.ctrl = ctrl; x.redir = redir; x.rpc = rpc;
    x.iack = iack; x.mie = m; x.cause = c; x.epc = e;
    sb_q.push_back(x);
  endtask

  // Monitor: compares the DUT against the oldest expectation mid-cycle.
  initial begin
    exp_t        x;
    logic [7:0]  act_ctrl;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        act_ctrl = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
                    flush_if_id, flush_id_ex, flush_ex_mem};
        n_checks++;
        if (act_ctrl === x.ctrl && redirect === x.redir && redirect_pc === x.rpc &&
            IACK_n === x.iack && mie === x.mie && cause === x.cause && epc === x.epc)
          n_pass++;
        else
          $display("[TB] FAIL %s: got ctrl=%b redir=%b rpc=%h iack=%b mie=%b cause=%0d epc=%h, expected ctrl=%b redir=%b rpc=%h iack=%b mie=%b cause=%0d epc=%h",
                   x.name, act_ctrl, redirect, redirect_pc, IACK_n, mie, cause, epc,
                   x.ctrl, x.redir, x.rpc, x.iack, x.mie, x.cause, x.epc);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0;
    {mreq, ACKD_n, ACKI_n, load_use, jump_ex, jump_mem, jump_wb, mret_ex} = F_IDLE;
    OINT_n = 3'b111;
    pc_id  = 32'd0;

    // Reset and idle
    for (int i = 0; i < 2; i++) begin
      applyStimulus(F_IDLE, 3'b111, 32'h0);
      checkOutput("reset", C_NONE, 0, 32'h0, 1, 1, 2'd0, 32'h0);
    end
    applyStimulus(F_IDLE, 3'b111, 32'h0);
    rst_n = 1'b1;
    checkOutput("reset_release", C_NONE, 0, 32'h0, 1, 1, 2'd0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(F_IDLE, 3'b111, 32'h0);
      checkOutput("idle", C_NONE, 0, 32'h0, 1, 1, 2'd0, 32'h0);
    end

    // Data-memory wait beats jump_wb, then the flushes appear
    for (int i = 0; i < 3; i++) begin
      applyStimulus(F_DMEM | F_JWB, 3'b111, 32'h0);
      checkOutput("dmem_wait_over_jump_wb", C_STALL, 0, 32'h0, 1, 1, 2'd0, 32'h0);
    end
    applyStimulus(8'h80 | F_JWB, 3'b111, 32'h0);
    checkOutput("jump_wb_flush", C_FL3, 0, 32'h0, 1, 1, 2'd0, 32'h0);
    applyStimulus(F_IDLE, 3'b111, 32'h0);
    checkOutput("idle_after_jump", C_NONE, 0, 32'h0, 1, 1, 2'd0, 32'h0);

    // Load-use and instruction-memory wait
    applyStimulus(F_LU, 3'b111, 32'h0);
    checkOutput("load_use", C_LU, 0, 32'h0, 1, 1, 2'd0, 32'h0);
    applyStimulus(F_IDLE, 3'b111, 32'h0);
    checkOutput("idle_after_lu", C_NONE, 0, 32'h0, 1, 1, 2'd0, 32'h0);
    applyStimulus(F_ACKI, 3'b111, 32'h0);
    checkOutput("imem_wait", C_SPF, 0, 32'h0, 1, 1, 2'd0, 32'h0);
    applyStimulus(F_IDLE, 3'b111, 32'h0);
    checkOutput("idle_after_imem", C_NONE, 0, 32'h0, 1, 1, 2'd0, 32'h0);

    // Level-1 interrupt: 2-cycle synchronizer, take, ACK, release, vector 0x110
    for (int i = 0; i < 2; i++) begin
      applyStimulus(F_IDLE, 3'b101, 32'h40);
      checkOutput("irq1_sync", C_NONE, 0, 32'h0, 1, 1, 2'd0, 32'h0);
    end
    applyStimulus(F_IDLE, 3'b101, 32'h40);
    checkOutput("irq1_take", C_SPF, 0, 32'h0, 1, 1, 2'd0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(F_IDLE, 3'b101, 32'h40);
      checkOutput("irq1_ack", C_SPF, 0, 32'h0, 0, 1, 2'd1, 32'h40);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(F_IDLE, 3'b111, 32'h40);
      checkOutput("irq1_release_ack", C_SPF, 0, 32'h0, 0, 1, 2'd1, 32'h40);
    end
    applyStimulus(F_IDLE, 3'b111, 32'h40);
    checkOutput("irq1_redirect", C_FIF, 1, 32'h110, 1, 1, 2'd1, 32'h40);
    applyStimulus(F_IDLE, 3'b111, 32'h40);
    checkOutput("irq1_handler_mie0", C_NONE, 0, 32'h0, 1, 0, 2'd1, 32'h40);

    // Level-2 request held while mie=0, then mret re-enables and it is taken
    for (int i = 0; i < 3; i++) begin
      applyStimulus(F_IDLE, 3'b011, 32'h80);
      checkOutput("irq2_masked", C_NONE, 0, 32'h0, 1, 0, 2'd1, 32'h40);
    end
    applyStimulus(F_MRET, 3'b011, 32'h80);
    checkOutput("mret", C_MRET, 1, 32'h40, 1, 0, 2'd1, 32'h40);
    applyStimulus(F_IDLE, 3'b011, 32'h80);
    checkOutput("after_mret_invalid_id", C_NONE, 0, 32'h0, 1, 1, 2'd1, 32'h40);
    applyStimulus(F_IDLE, 3'b011, 32'h80);
    checkOutput("irq2_take", C_SPF, 0, 32'h0, 1, 1, 2'd1, 32'h40);
    applyStimulus(F_IDLE, 3'b011, 32'h80);
    checkOutput("irq2_ack", C_SPF, 0, 32'h0, 0, 1, 2'd2, 32'h80);
    applyStimulus(F_DMEM, 3'b111, 32'h80);
    checkOutput("ack_dmem_wait", C_STALL, 0, 32'h0, 0, 1, 2'd2, 32'h80);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(F_IDLE, 3'b111, 32'h80);
      checkOutput("irq2_release_ack", C_SPF, 0, 32'h0, 0, 1, 2'd2, 32'h80);
    end
    applyStimulus(F_DMEM, 3'b111, 32'h80);
    checkOutput("redirect_dmem_hold", C_STALL, 1, 32'h120, 1, 1, 2'd2, 32'h80);
    applyStimulus(F_IDLE, 3'b111, 32'h80);
    checkOutput("irq2_redirect", C_FIF, 1, 32'h120, 1, 1, 2'd2, 32'h80);
    applyStimulus(F_IDLE, 3'b111, 32'h80);
    checkOutput("irq2_handler_mie0", C_NONE, 0, 32'h0, 1, 0, 2'd2, 32'h80);

    // Jumps in flight block the take; reset during ACK
    applyStimulus(F_MRET, 3'b111, 32'h80);
    checkOutput("mret2", C_MRET, 1, 32'h80, 1, 0, 2'd2, 32'h80);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(F_IDLE, 3'b110, 32'hC0);
      checkOutput("irq0_sync", C_NONE, 0, 32'h0, 1, 1, 2'd2, 32'h80);
    end
    applyStimulus(F_JEX, 3'b110, 32'hC0);
    checkOutput("no_take_jump_ex", C_NONE, 0, 32'h0, 1, 1, 2'd2, 32'h80);
    applyStimulus(F_JMEM, 3'b110, 32'hC0);
    checkOutput("no_take_jump_mem", C_NONE, 0, 32'h0, 1, 1, 2'd2, 32'h80);
    applyStimulus(F_JWB, 3'b110, 32'hC0);
    checkOutput("jump_wb_beats_irq", C_FL3, 0, 32'h0, 1, 1, 2'd2, 32'h80);
    applyStimulus(F_IDLE, 3'b110, 32'hC0);
    checkOutput("no_take_invalid_id", C_NONE, 0, 32'h0, 1, 1, 2'd2, 32'h80);
    applyStimulus(F_IDLE, 3'b110, 32'hC0);
    checkOutput("irq0_take", C_SPF, 0, 32'h0, 1, 1, 2'd2, 32'h80);
    applyStimulus(F_IDLE, 3'b110, 32'hC0);
    checkOutput("irq0_ack", C_SPF, 0, 32'h0, 0, 1, 2'd0, 32'hC0);
    applyStimulus(F_IDLE, 3'b111, 32'hC0);
    rst_n = 1'b0;
    checkOutput("async_reset_in_ack", C_NONE, 0, 32'h0, 1, 1, 2'd0, 32'h0);
    applyStimulus(F_IDLE, 3'b111, 32'h0);
    rst_n = 1'b1;
    checkOutput("reset_release2", C_NONE, 0, 32'h0, 1, 1, 2'd0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(F_IDLE, 3'b111, 32'h0);
      checkOutput("idle_final", C_NONE, 0, 32'h0, 1, 1, 2'd0, 32'h0);
    end

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
